// File: rtl/ex_stage.sv
// Execute stage: ALU, 32-step restoring divider, load/store lane generation and
// data_sram request issue, with valid/allow_in handshakes toward ID and MEM.
`ifndef to_EX_data_width
`define to_EX_data_width 210
`endif
`ifndef to_MEM_data_width
`define to_MEM_data_width 128
`endif
`ifndef FORWRD_DATA_WIDTH
`define FORWRD_DATA_WIDTH 38
`endif

module ex_stage #(
  parameter int DIV_STEPS = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            csr_reset,
  input  logic                            mem_ex,
  input  logic                            ID_to_EX_valid,
  output logic                            EX_allow_in,
  input  logic [`to_EX_data_width-1:0]    to_EX_data,
  input  logic                            MEM_allow_in,
  output logic                            EX_to_MEM_valid,
  output logic [`to_MEM_data_width-1:0]   to_MEM_data,
  output logic                            data_sram_en,
  output logic [3:0]                      data_sram_we,
  output logic [31:0]                     data_sram_addr,
  output logic [31:0]                     data_sram_wdata,
  output logic [`FORWRD_DATA_WIDTH-1:0]   EX_forward,
  output logic                            EX_fwd_blocked
);

  localparam int CNT_W = $clog2(DIV_STEPS);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} divState_t;

  logic                          r_exValid;
  logic [`to_EX_data_width-1:0]  r_exData;

  logic [31:0] w_pc, w_src1, w_src2, w_rkd, w_csrWmask;
  logic [11:0] w_aluOp;
  logic        w_divEn, w_ld1, w_ld2, w_ld4, w_ldSigned, w_st1, w_st2, w_st4;
  logic [1:0]  w_divOp;
  logic [4:0]  w_dest, w_rj;
  logic        w_grWe, w_exSys, w_isErtn, w_opCsr;
  logic [13:0] w_csrNum;

  assign {w_pc, w_src1, w_src2, w_aluOp, w_divEn, w_divOp, w_ld1, w_ld2, w_ld4, w_ldSigned,
          w_st1, w_st2, w_st4, w_rkd, w_dest, w_grWe, w_exSys, w_isErtn, w_opCsr, w_csrNum,
          w_csrWmask, w_rj} = r_exData;

  // ALU: one-hot op select, OR-combined
  logic [31:0] w_addRes, w_sraRes, w_aluResult;
  logic [32:0] w_subFull;
  logic        w_slt, w_sltu;

  assign w_addRes  = w_src1 + w_src2;
  assign w_subFull = {1'b0, w_src1} + {1'b0, ~w_src2} + 33'd1;
  assign w_sltu    = ~w_subFull[32];
  assign w_slt     = (w_src1[31] & ~w_src2[31]) | (~(w_src1[31] ^ w_src2[31]) & w_subFull[31]);
  assign w_sraRes  = $signed(w_src1) >>> w_src2[4:0];

  assign w_aluResult = ({32{w_aluOp[0]}}  & w_addRes)
                     | ({32{w_aluOp[1]}}  & w_subFull[31:0])
                     | ({32{w_aluOp[2]}}  & {31'd0, w_slt})
                     | ({32{w_aluOp[3]}}  & {31'd0, w_sltu})
                     | ({32{w_aluOp[4]}}  & (w_src1 & w_src2))
                     | ({32{w_aluOp[5]}}  & ~(w_src1 | w_src2))
                     | ({32{w_aluOp[6]}}  & (w_src1 | w_src2))
                     | ({32{w_aluOp[7]}}  & (w_src1 ^ w_src2))
                     | ({32{w_aluOp[8]}}  & (w_src1 << w_src2[4:0]))
                     | ({32{w_aluOp[9]}}  & (w_src1 >> w_src2[4:0]))
                     | ({32{w_aluOp[10]}} & w_sraRes)
                     | ({32{w_aluOp[11]}} & w_src2);

  // Divider: magnitudes are divided, signs and the divide-by-zero case fixed up at the end
  divState_t        r_divState;
  logic [CNT_W-1:0] r_divCnt;
  logic [31:0]      r_quot, r_rem, r_divisor, r_dividendRaw;
  logic             r_negQ, r_negR, r_divZero;

  logic        w_divSigned, w_divStart, w_handoff, w_readyGo;
  logic [32:0] w_remShift, w_diff;
  logic [31:0] w_qFinal, w_rFinal, w_divResult, w_exResult;

  assign w_divSigned = ~w_divOp[0];
  assign w_divStart  = r_exValid & w_divEn & ~csr_reset;
  assign w_remShift  = {r_rem, r_quot[31]};
  assign w_diff      = w_remShift - {1'b0, r_divisor};

  always_ff @(posedge clk) begin
    if (reset || csr_reset) begin
      r_divState    <= DIV_IDLE;
      r_divCnt      <= '0;
      r_quot        <= '0;
      r_rem         <= '0;
      r_divisor     <= '0;
      r_dividendRaw <= '0;
      r_negQ        <= 1'b0;
      r_negR        <= 1'b0;
      r_divZero     <= 1'b0;
    end else begin
      case (r_divState)
        DIV_IDLE: begin
          if (w_divStart) begin
            r_divState    <= DIV_BUSY;
            r_divCnt      <= '0;
            r_quot        <= (w_divSigned && w_src1[31]) ? -w_src1 : w_src1;
            r_divisor     <= (w_divSigned && w_src2[31]) ? -w_src2 : w_src2;
            r_rem         <= '0;
            r_dividendRaw <= w_src1;
            r_negQ        <= w_divSigned & (w_src1[31] ^ w_src2[31]);
            r_negR        <= w_divSigned & w_src1[31];
            r_divZero     <= (w_src2 == 32'd0);
          end
        end
        DIV_BUSY: begin
          r_quot <= {r_quot[30:0], ~w_diff[32]};
          r_rem  <= w_diff[32] ? w_remShift[31:0] : w_diff[31:0];
          r_divCnt <= r_divCnt + 1'b1;
          if (r_divCnt == CNT_W'(DIV_STEPS - 1)) begin
            r_divState <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (r_exValid && MEM_allow_in) begin
            r_divState <= DIV_IDLE;
          end
        end
        default: r_divState <= DIV_IDLE;
      endcase
    end
  end

  assign w_qFinal    = r_divZero ? 32'hFFFF_FFFF : (r_negQ ? -r_quot : r_quot);
  assign w_rFinal    = r_divZero ? r_dividendRaw : (r_negR ? -r_rem : r_rem);
  assign w_divResult = w_divOp[1] ? w_rFinal : w_qFinal;
  assign w_exResult  = w_divEn ? w_divResult : w_aluResult;

  // Pipeline handshake: a divide holds EX until the FSM reports DONE
  assign w_readyGo       = ~w_divEn | (r_divState == DIV_DONE);
  assign EX_allow_in     = ~r_exValid | (w_readyGo & MEM_allow_in);
  assign EX_to_MEM_valid = r_exValid & w_readyGo & ~csr_reset;
  assign w_handoff       = w_readyGo & MEM_allow_in;

  always_ff @(posedge clk) begin
    if (reset || csr_reset) begin
      r_exValid <= 1'b0;
    end else if (EX_allow_in) begin
      r_exValid <= ID_to_EX_valid;
    end
    if (reset) begin
      r_exData <= '0;
    end else if (ID_to_EX_valid && EX_allow_in) begin
      r_exData <= to_EX_data;
    end
  end

  // Memory request: issued only on the hand-off cycle so a stalled access is not repeated
  logic       w_isLoad, w_isStore;
  logic [1:0] w_addrLo;
  logic [3:0] w_laneWe;

  assign w_isLoad  = w_ld1 | w_ld2 | w_ld4;
  assign w_isStore = w_st1 | w_st2 | w_st4;
  assign w_addrLo  = w_aluResult[1:0];

  always_comb begin
    w_laneWe = 4'b0000;
    if (w_st1) begin
      w_laneWe = 4'b0001 << w_addrLo;
    end else if (w_st2) begin
      w_laneWe = w_addrLo[1] ? 4'b1100 : 4'b0011;
    end else if (w_st4) begin
      w_laneWe = 4'b1111;
    end
  end

  assign data_sram_en    = r_exValid & (w_isLoad | w_isStore) & ~w_exSys & ~csr_reset & w_handoff;
  assign data_sram_we    = (data_sram_en & w_isStore & ~mem_ex) ? w_laneWe : 4'b0000;
  assign data_sram_addr  = w_aluResult;
  assign data_sram_wdata = w_st1 ? {4{w_rkd[7:0]}} : (w_st2 ? {2{w_rkd[15:0]}} : w_rkd);

  assign to_MEM_data = {w_pc, w_exResult, w_ld1, w_ld2, w_ld4, w_ldSigned, w_dest, w_grWe,
                        w_exSys, w_isErtn, w_opCsr, w_csrNum, w_csrWmask, w_rj};

  assign EX_forward     = r_exValid ? {w_dest, w_exResult, w_opCsr} : '0;
  assign EX_fwd_blocked = r_exValid & (w_isLoad | (w_divEn & (r_divState != DIV_DONE)));

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, divider corner cases, store lanes,
// flush during a divide and a stalled divide hand-off.
module tb_ex_stage;

  localparam int EXW  = 210;
  localparam int MEMW = 128;
  localparam int FWDW = 38;

  localparam logic [11:0] ALU_ADD = 12'h001;
  localparam logic [11:0] ALU_SUB = 12'h002;
  localparam logic [11:0] ALU_SLT = 12'h004;
  localparam logic [11:0] ALU_SRA = 12'h400;

  logic            clk = 1'b0;
  logic            reset, csr_reset, mem_ex, ID_to_EX_valid, MEM_allow_in;
  logic [EXW-1:0]  to_EX_data;
  logic            EX_allow_in, EX_to_MEM_valid, data_sram_en, EX_fwd_blocked;
  logic [MEMW-1:0] to_MEM_data;
  logic [3:0]      data_sram_we;
  logic [31:0]     data_sram_addr, data_sram_wdata;
  logic [FWDW-1:0] EX_forward;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [31:0] capResult, capAddr, capWdata, capPc;
  logic [3:0]  capWe;
  logic        capEn, capBlocked, capBlockedOk;
  int          capCycles;
  logic [FWDW-1:0] savedForward;

  ex_stage dut (
    .clk(clk), .reset(reset), .csr_reset(csr_reset), .mem_ex(mem_ex),
    .ID_to_EX_valid(ID_to_EX_valid), .EX_allow_in(EX_allow_in), .to_EX_data(to_EX_data),
    .MEM_allow_in(MEM_allow_in), .EX_to_MEM_valid(EX_to_MEM_valid), .to_MEM_data(to_MEM_data),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .EX_forward(EX_forward), .EX_fwd_blocked(EX_fwd_blocked)
  );

  always #5 clk = ~clk;

  // Counts every comparison and reports any mismatch on one line
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [EXW-1:0] makeOp(input logic [31:0] pc, input logic [31:0] s1,
                                            input logic [31:0] s2, input logic [11:0] aluOp,
                                            input logic divEn, input logic [1:0] divOp,
                                            input logic [2:0] ld, input logic [2:0] st,
                                            input logic [31:0] rkd, input logic [4:0] dest);
    return {pc, s1, s2, aluOp, divEn, divOp, ld, 1'b0, st, rkd, dest,
            1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 32'd0, 5'd0};
  endfunction

  // Drives one op into EX (called just after a posedge) and waits for its hand-off to MEM
  task automatic applyStimulus(input logic [EXW-1:0] op);
    to_EX_data     = op;
    ID_to_EX_valid = 1'b1;
    @(posedge clk); #1;
    ID_to_EX_valid = 1'b0;
    capBlockedOk = 1'b1;
    capCycles    = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (EX_to_MEM_valid) begin
        capCycles = cyc;
        break;
      end
      if (!(EX_fwd_blocked && !EX_allow_in)) capBlockedOk = 1'b0;
      @(posedge clk); #1;
    end
    if (capCycles < 0) checkOutput("handoff_timeout", 64'd0, 64'd1);
    capResult  = to_MEM_data[95:64];
    capPc      = to_MEM_data[127:96];
    capEn      = data_sram_en;
    capWe      = data_sram_we;
    capAddr    = data_sram_addr;
    capWdata   = data_sram_wdata;
    capBlocked = EX_fwd_blocked;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; csr_reset = 1'b0; mem_ex = 1'b0; ID_to_EX_valid = 1'b0;
    MEM_allow_in = 1'b1; to_EX_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_to_mem_valid", EX_to_MEM_valid, 0);
    checkOutput("rst_sram_en", data_sram_en, 0);
    checkOutput("rst_sram_we", data_sram_we, 0);
    checkOutput("rst_allow_in", EX_allow_in, 1);
    checkOutput("rst_forward", EX_forward, 0);
    @(posedge clk); #1;

    applyStimulus(makeOp(32'h1c00_0000, 32'd5, 32'd7, ALU_ADD, 0, 2'b00, 3'b000, 3'b000, 0, 5'd3));
    checkOutput("add_latency", capCycles, 0);
    checkOutput("add_result", capResult, 32'd12);
    checkOutput("add_pc", capPc, 32'h1c00_0000);
    checkOutput("add_sram_en", capEn, 0);
    checkOutput("add_blocked", capBlocked, 0);

    applyStimulus(makeOp(32'h1c00_0004, 32'd5, 32'd7, ALU_SUB, 0, 2'b00, 3'b000, 3'b000, 0, 5'd3));
    checkOutput("sub_result", capResult, 32'hFFFF_FFFE);
    applyStimulus(makeOp(32'h1c00_0008, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 0, 2'b00, 3'b000, 3'b000, 0, 5'd3));
    checkOutput("slt_result", capResult, 32'd1);
    applyStimulus(makeOp(32'h1c00_000c, 32'h8000_0000, 32'd4, ALU_SRA, 0, 2'b00, 3'b000, 3'b000, 0, 5'd3));
    checkOutput("sra_result", capResult, 32'hF800_0000);

    applyStimulus(makeOp(32'h1c00_0010, 32'hFFFF_FFF9, 32'd2, ALU_ADD, 1, 2'b00, 3'b000, 3'b000, 0, 5'd4));
    checkOutput("divw_cycles", capCycles, 33);
    checkOutput("divw_stalled", capBlockedOk, 1);
    checkOutput("divw_q", capResult, 32'hFFFF_FFFD);
    checkOutput("divw_done_blocked", capBlocked, 0);
    applyStimulus(makeOp(32'h1c00_0014, 32'hFFFF_FFF9, 32'd2, ALU_ADD, 1, 2'b10, 3'b000, 3'b000, 0, 5'd4));
    checkOutput("modw_r", capResult, 32'hFFFF_FFFF);
    applyStimulus(makeOp(32'h1c00_0018, 32'd9, 32'd0, ALU_ADD, 1, 2'b01, 3'b000, 3'b000, 0, 5'd4));
    checkOutput("divwu_by0", capResult, 32'hFFFF_FFFF);
    applyStimulus(makeOp(32'h1c00_001c, 32'd9, 32'd0, ALU_ADD, 1, 2'b11, 3'b000, 3'b000, 0, 5'd4));
    checkOutput("modwu_by0", capResult, 32'd9);
    applyStimulus(makeOp(32'h1c00_0020, 32'h8000_0000, 32'hFFFF_FFFF, ALU_ADD, 1, 2'b00, 3'b000, 3'b000, 0, 5'd4));
    checkOutput("divw_ovf_q", capResult, 32'h8000_0000);
    applyStimulus(makeOp(32'h1c00_0024, 32'h8000_0000, 32'hFFFF_FFFF, ALU_ADD, 1, 2'b10, 3'b000, 3'b000, 0, 5'd4));
    checkOutput("modw_ovf_r", capResult, 32'd0);

    applyStimulus(makeOp(32'h1c00_0028, 32'h1000, 32'd3, ALU_ADD, 0, 2'b00, 3'b000, 3'b100, 32'hAB, 5'd0));
    checkOutput("stb_en", capEn, 1);
    checkOutput("stb_we", capWe, 4'b1000);
    checkOutput("stb_wdata", capWdata, 32'hABAB_ABAB);
    checkOutput("stb_addr", capAddr, 32'h1003);
    mem_ex = 1'b1;
    applyStimulus(makeOp(32'h1c00_002c, 32'h1000, 32'd3, ALU_ADD, 0, 2'b00, 3'b000, 3'b100, 32'hAB, 5'd0));
    checkOutput("stb_memex_we", capWe, 4'b0000);
    mem_ex = 1'b0;
    applyStimulus(makeOp(32'h1c00_0030, 32'h1000, 32'd2, ALU_ADD, 0, 2'b00, 3'b000, 3'b010, 32'h1234, 5'd0));
    checkOutput("sth_we", capWe, 4'b1100);
    checkOutput("sth_wdata", capWdata, 32'h1234_1234);
    applyStimulus(makeOp(32'h1c00_0034, 32'h2000, 32'd0, ALU_ADD, 0, 2'b00, 3'b001, 3'b000, 0, 5'd6));
    checkOutput("ldw_en", capEn, 1);
    checkOutput("ldw_we", capWe, 4'b0000);
    checkOutput("ldw_blocked", capBlocked, 1);

    // Flush a divide part-way through, then confirm a fresh divide takes the full latency
    to_EX_data = makeOp(32'h1c00_0038, 32'd100, 32'd7, ALU_ADD, 1, 2'b01, 3'b000, 3'b000, 0, 5'd7);
    ID_to_EX_valid = 1'b1;
    @(posedge clk); #1;
    ID_to_EX_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 csr_reset = 1'b1;
    @(negedge clk);
    checkOutput("flush_to_mem_valid", EX_to_MEM_valid, 0);
    @(posedge clk); #1;
    csr_reset = 1'b0;
    @(negedge clk);
    checkOutput("flush_allow_in", EX_allow_in, 1);
    checkOutput("flush_blocked", EX_fwd_blocked, 0);
    checkOutput("flush_forward", EX_forward, 0);
    @(posedge clk); #1;
    applyStimulus(makeOp(32'h1c00_003c, 32'd100, 32'd7, ALU_ADD, 1, 2'b01, 3'b000, 3'b000, 0, 5'd7));
    checkOutput("post_flush_cycles", capCycles, 33);
    checkOutput("post_flush_q", capResult, 32'd14);

    // Divide finishes while MEM is stalled: result must hold until released
    MEM_allow_in = 1'b0;
    to_EX_data = makeOp(32'h1c00_0040, 32'd100, 32'd7, ALU_ADD, 1, 2'b11, 3'b000, 3'b000, 0, 5'd9);
    ID_to_EX_valid = 1'b1;
    @(posedge clk); #1;
    ID_to_EX_valid = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_valid", EX_to_MEM_valid, 1);
    checkOutput("stall_result", to_MEM_data[95:64], 32'd2);
    checkOutput("stall_forward", EX_forward, {5'd9, 32'd2, 1'b0});
    savedForward = EX_forward;
    repeat (5) @(negedge clk);
    checkOutput("stall_forward_hold", EX_forward, savedForward);
    checkOutput("stall_allow_in", EX_allow_in, 0);
    @(posedge clk); #1;
    MEM_allow_in = 1'b1;
    @(negedge clk);
    checkOutput("release_valid", EX_to_MEM_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("release_single", EX_to_MEM_valid, 0);
    @(posedge clk); #1;
    applyStimulus(makeOp(32'h1c00_0044, 32'hFFFF_FFF9, 32'd2, ALU_ADD, 1, 2'b00, 3'b000, 3'b000, 0, 5'd4));
    checkOutput("post_stall_cycles", capCycles, 33);
    checkOutput("post_stall_q", capResult, 32'hFFFF_FFFD);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
